rob_controller: RTL and testbench
=================================

Name: rob_controller

Overview:
- Sequencing controller for the reorder-buffer data array in the Tomasulo datapath.
- Owns the head/tail pointers, occupancy count and per-entry ready bits.
- Grants tags to the issue stage and marks entries complete from CDB broadcasts.
- Drives in-order commit to the register file through a valid/ack handshake, and sequences the flush on a branch mispredict found at commit.

Parameters:
- TAG_W, 3: ROB tag width.
- DEPTH, 2**TAG_W: number of entries; must equal 2**TAG_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- alloc_req  in  1  issue stage requests an entry
- alloc_grant  out  1  entry granted this cycle (combinational from registered state)
- alloc_tag  out  TAG_W  tag granted; equals tail pointer
- rob_we  out  1  write strobe to data array; alloc_req & alloc_grant
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB tag (the tag field of the CDB struct)
- head_tag  out  TAG_W  read address of data array; equals head pointer
- head_is_br  in  1  head entry is a BR (from data array)
- head_mispredict  in  1  head branch outcome differs from its predict bit
- commit_valid  out  1  head entry ready to retire
- commit_ack  in  1  register file / memory accepted commit
- flush  out  1  one-cycle flush pulse to ROB, reservation stations, RAT
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset (rst_n low at posedge clk):
  - head = 0, tail = 0, count = 0, all ready bits = 0, state = RUN.
  - Outputs: alloc_grant = 0 during reset; flush = 0, commit_valid = 0, full = 0, empty = 1.
  - Reset dominates every other input, including mid-flush.
- FSM states: RUN and FLUSH.
- RUN:
  - alloc_grant = ~full. On grant: tail <= tail+1 mod DEPTH; ready[tail] <= 0.
  - CDB: if cdb_valid and the entry at cdb_tag is occupied, ready[cdb_tag] <= 1. A CDB hit on an unoccupied entry is ignored.
  - commit_valid = ~empty & ready[head].
  - On commit_valid & commit_ack:
    - head_is_br & head_mispredict: go to FLUSH. The commit still counts, since the branch itself retires.
    - Otherwise: head <= head+1; ready[head] <= 0.
  - commit_ack while commit_valid is low is ignored.
- FLUSH, exactly one cycle:
  - flush = 1, alloc_grant = 0, commit_valid = 0.
  - head, tail and count all go to 0, and all ready bits clear. CDB input is ignored.
  - Next state is RUN.
- Counting: count is TAG_W+1 bits. count <= count + grant − retire; a grant and a retire in the same cycle leave count unchanged.
- Full/empty:
  - full and empty are derived from the registered count only.
  - When full, alloc is denied even if a commit retires in the same cycle; there is no same-cycle bypass.
- Simultaneous events:
  - A CDB hit on the head in the same cycle commit_valid is evaluated does not raise commit_valid until the next cycle.
  - A grant and a CDB hit targeting the tail tag in the same cycle: the grant wins and ready stays 0.
- Wrap-around: pointers are TAG_W bits and wrap naturally; full is decided by count, not by pointer equality.
- Latency:
  - Grant is same-cycle.
  - A ready bit is visible 1 cycle after the CDB broadcast.
  - flush rises 1 cycle after the mispredicting commit handshake.

Optional Feature:
- Macro ROB_PERF_CNT_EN.
- When defined: adds outputs perf_commits (16 bits, increments on every retire) and perf_flushes (16 bits, increments on entry to FLUSH). Both saturate at 16'hFFFF and are cleared by rst_n.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (lc3b_types):
  - rob_state_t enum {RUN, FLUSH}.
  - ROB_TAG_W constant.
  - Existing lc3b_opcode, lc3b_reg and CDB types stay there.
- One sub-module: rob_ptr_ctr, a TAG_W-bit wrapping pointer with increment and clear, instantiated for head and tail.

Test Plan:
- Reset: apply rst_n = 0 then release → empty = 1, full = 0, alloc_tag = 0, flush = 0, commit_valid = 0.
- Fill: alloc_req held for 9 cycles with DEPTH = 8 → tags 0..7 granted, full = 1 after the 8th, 9th request sees alloc_grant = 0.
- Out-of-order completion:
  - Stimulus: alloc tags 0, 1, 2; CDB tags 2, then 0, then 1; commit_ack tied 1.
  - Response: commit_valid stays low until tag 0 is ready, then tags 0, 1, 2 retire on consecutive cycles; empty = 1 afterwards.
- Wrap: run 20 alloc/commit pairs → tags wrap 7→0 correctly, count never exceeds 8 nor underflows.
- Mispredict: alloc 4 entries, head is BR with head_mispredict = 1, CDB marks it ready, ack → next cycle flush = 1 for exactly 1 cycle, empty = 1, alloc_tag = 0, later CDB on old tags ignored.
- Full with commit: full and head ready, alloc_req = 1 and commit_ack = 1 in the same cycle → alloc_grant = 0, count becomes 7, grant succeeds the following cycle.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b Tomasulo datapath types: opcodes, register ids, CDB broadcast and ROB control types.
package lc3b_types;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LDB  = 4'b0010,
        OP_STB  = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDW  = 4'b0110,
        OP_STW  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_SHF  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } lc3b_opcode;

    typedef logic [2:0]  lc3b_reg;
    typedef logic [15:0] lc3b_word;

    localparam int ROB_TAG_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        lc3b_word             value;
    } lc3b_cdb_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_t;

endpackage

// File: rtl/rob_ptr_ctr.sv
// TAG_W-bit wrapping ROB pointer with increment and synchronous clear; used for head and tail.
module rob_ptr_ctr #(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [TAG_W-1:0] ptr
);

    logic [TAG_W-1:0] ptr_d;
    logic [TAG_W-1:0] ptr_q;

    // next pointer: clear wins over increment, wrap is the natural modulo of TAG_W bits
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + TAG_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rob_controller.sv
// Reorder-buffer sequencing controller: tag grant, CDB completion, in-order commit and mispredict flush.
// Optional macro ROB_PERF_CNT_EN adds saturating commit/flush performance counters.
module rob_controller
    import lc3b_types::*;
#(
    parameter int TAG_W = ROB_TAG_W,
    parameter int DEPTH = 2**TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    output logic             alloc_grant,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             rob_we,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic [TAG_W-1:0] head_tag,
    input  logic             head_is_br,
    input  logic             head_mispredict,
    output logic             commit_valid,
    input  logic             commit_ack,
    output logic             flush,
`ifdef ROB_PERF_CNT_EN
    output logic [15:0]      perf_commits,
    output logic [15:0]      perf_flushes,
`endif
    output logic             full,
    output logic             empty
);

    rob_state_t       state_d, state_q;
    logic [TAG_W:0]   count_d, count_q;
    logic [DEPTH-1:0] ready_d, ready_q;
    logic [TAG_W-1:0] head_ptr, tail_ptr, cdb_off;

    logic in_run, full_int, empty_int;
    logic grant_int, cv_int, retire, mis_commit, head_inc, cdb_hit, ptr_clr;

    assign in_run    = (state_q == RUN);
    assign full_int  = (count_q == (TAG_W+1)'(DEPTH));
    assign empty_int = (count_q == '0);

    // outputs are forced to their idle values while reset is asserted
    assign grant_int  = rst_n & in_run & ~full_int;
    assign cv_int     = rst_n & in_run & ~empty_int & ready_q[head_ptr];
    assign retire     = cv_int & commit_ack;
    assign mis_commit = retire & head_is_br & head_mispredict;
    assign head_inc   = retire & ~mis_commit;
    assign ptr_clr    = ~in_run;

    // an entry is occupied when its distance from head is below the occupancy count
    assign cdb_off = cdb_tag - head_ptr;
    assign cdb_hit = cdb_valid & in_run & ({1'b0, cdb_off} < count_q);

    rob_ptr_ctr #(.TAG_W(TAG_W)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ptr_clr),
        .inc   (head_inc),
        .ptr   (head_ptr)
    );

    rob_ptr_ctr #(.TAG_W(TAG_W)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ptr_clr),
        .inc   (grant_int & alloc_req),
        .ptr   (tail_ptr)
    );

    // next state, occupancy and ready bits; grant clear is applied last so it beats a CDB hit on the tail
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ready_d = ready_q;
        case (state_q)
            RUN: begin
                if (mis_commit) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
                count_d = count_q + {{TAG_W{1'b0}}, grant_int & alloc_req}
                                  - {{TAG_W{1'b0}}, retire};
                if (cdb_hit) begin
                    ready_d[cdb_tag] = 1'b1;
                end else begin
                    ready_d = ready_d;
                end
                if (head_inc) begin
                    ready_d[head_ptr] = 1'b0;
                end else begin
                    ready_d = ready_d;
                end
                if (grant_int & alloc_req) begin
                    ready_d[tail_ptr] = 1'b0;
                end else begin
                    ready_d = ready_d;
                end
            end
            FLUSH: begin
                state_d = RUN;
                count_d = '0;
                ready_d = '0;
            end
            default: begin
                state_d = RUN;
                count_d = '0;
                ready_d = '0;
            end
        endcase
    end

    // control state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            count_q <= '0;
            ready_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [15:0] perf_commits_d, perf_commits_q;
    logic [15:0] perf_flushes_d, perf_flushes_q;

    // saturating event counters
    always_comb begin
        perf_commits_d = perf_commits_q;
        perf_flushes_d = perf_flushes_q;
        if (retire && (perf_commits_q != 16'hFFFF)) begin
            perf_commits_d = perf_commits_q + 16'd1;
        end else begin
            perf_commits_d = perf_commits_q;
        end
        if (mis_commit && (perf_flushes_q != 16'hFFFF)) begin
            perf_flushes_d = perf_flushes_q + 16'd1;
        end else begin
            perf_flushes_d = perf_flushes_q;
        end
    end

    // performance counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_commits_q <= 16'd0;
            perf_flushes_q <= 16'd0;
        end else begin
            perf_commits_q <= perf_commits_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_commits = perf_commits_q;
    assign perf_flushes = perf_flushes_q;
`endif

    assign alloc_grant  = grant_int;
    assign alloc_tag    = tail_ptr;
    assign rob_we       = alloc_req & grant_int;
    assign head_tag     = head_ptr;
    assign commit_valid = cv_int;
    assign flush        = rst_n & (state_q == FLUSH);
    assign full         = rst_n & full_int;
    assign empty        = ~rst_n | empty_int;

endmodule

// File: tb/tb_rob_controller.sv
// Directed table-driven bench for rob_controller (DEPTH = 8); vectors pack inputs and expected outputs.
module tb_rob_controller;

    logic       clk = 1'b0;
    logic       rst_n, alloc_req, cdb_valid, head_is_br, head_mispredict, commit_ack;
    logic [2:0] cdb_tag;
    logic       alloc_grant, rob_we, commit_valid, flush, full, empty;
    logic [2:0] alloc_tag, head_tag;
`ifdef ROB_PERF_CNT_EN
    logic [15:0] perf_commits, perf_flushes;
`endif

    // in : {rst_n, alloc_req, cdb_valid, cdb_tag[2:0], head_is_br, head_mispredict, commit_ack}
    // exp: {alloc_grant, alloc_tag[2:0], commit_valid, head_tag[2:0], flush, full, empty, rob_we}
    typedef struct {
        logic [8:0]  in;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    rob_controller #(.TAG_W(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_req       (alloc_req),
        .alloc_grant     (alloc_grant),
        .alloc_tag       (alloc_tag),
        .rob_we          (rob_we),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .head_tag        (head_tag),
        .head_is_br      (head_is_br),
        .head_mispredict (head_mispredict),
        .commit_valid    (commit_valid),
        .commit_ack      (commit_ack),
        .flush           (flush),
`ifdef ROB_PERF_CNT_EN
        .perf_commits    (perf_commits),
        .perf_flushes    (perf_flushes),
`endif
        .full            (full),
        .empty           (empty)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [8:0] in, input logic [11:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    // drive at negedge, compare 1ns later; the following posedge applies the vector
    task automatic apply(input vec_t v, input string name);
        logic [11:0] act;
        @(negedge clk);
        {rst_n, alloc_req, cdb_valid, cdb_tag, head_is_br, head_mispredict, commit_ack} = v.in;
        #1;
        act = {alloc_grant, alloc_tag, commit_valid, head_tag, flush, full, empty, rob_we};
        n_checks++;
        if (act === v.exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got g_tag_cv_head_fl_fu_em_we=%b_%b_%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b_%b_%b",
                     name, act[11], act[10:8], act[7], act[6:4], act[3], act[2], act[1], act[0],
                     v.exp[11], v.exp[10:8], v.exp[7], v.exp[6:4], v.exp[3], v.exp[2], v.exp[1], v.exp[0]);
        end
    endtask

    initial begin
        vec_t v;
        {rst_n, alloc_req, cdb_valid, cdb_tag, head_is_br, head_mispredict, commit_ack} = 9'b0_1_0_000_0_0_0;
        @(posedge clk);

        // reset state, with alloc_req high to show grant is held off
        add(9'b0_1_0_000_0_0_0, 12'b0_000_0_000_0_0_1_0);
        // fill: tags 0..7 granted, ninth request denied
        for (int k = 0; k < 8; k++) begin
            logic [2:0] t;
            t = k[2:0];
            add(9'b1_1_0_000_0_0_0, {1'b1, t, 1'b0, 3'b000, 1'b0, 1'b0, (k == 0), 1'b1});
        end
        add(9'b1_1_0_000_0_0_0, 12'b0_000_0_000_0_1_0_0);
        // full with commit: no same-cycle bypass, grant the following cycle
        add(9'b1_0_1_000_0_0_0, 12'b0_000_0_000_0_1_0_0);
        add(9'b1_1_0_000_0_0_1, 12'b0_000_1_000_0_1_0_0);
        add(9'b1_1_0_000_0_0_0, 12'b1_000_0_001_0_0_0_1);
        add(9'b1_0_0_000_0_0_0, 12'b0_001_0_001_0_1_0_0);
        // reset from a full ROB
        add(9'b0_1_0_000_0_0_0, 12'b0_001_0_001_0_0_1_0);
        add(9'b1_0_0_000_0_0_0, 12'b1_000_0_000_0_0_1_0);
        // out-of-order completion: alloc 0,1,2 (CDB on tail during grant), CDB 2,0,1, ack held
        add(9'b1_1_0_000_0_0_0, 12'b1_000_0_000_0_0_1_1);
        add(9'b1_1_0_000_0_0_0, 12'b1_001_0_000_0_0_0_1);
        add(9'b1_1_1_010_0_0_0, 12'b1_010_0_000_0_0_0_1);
        add(9'b1_0_1_010_0_0_0, 12'b1_011_0_000_0_0_0_0);
        add(9'b1_0_1_000_0_0_1, 12'b1_011_0_000_0_0_0_0);
        add(9'b1_0_1_001_0_0_1, 12'b1_011_1_000_0_0_0_0);
        add(9'b1_0_0_000_0_0_1, 12'b1_011_1_001_0_0_0_0);
        add(9'b1_0_0_000_0_0_1, 12'b1_011_1_010_0_0_0_0);
        add(9'b1_0_0_000_0_0_1, 12'b1_011_0_011_0_0_1_0);
        add(9'b1_1_0_000_0_0_0, 12'b1_011_0_011_0_0_1_1);
        add(9'b1_0_1_011_0_0_0, 12'b1_100_0_011_0_0_0_0);
        add(9'b1_0_0_000_0_0_1, 12'b1_100_1_011_0_0_0_0);
        // mispredict: alloc 4..7, head is a mispredicted BR
        add(9'b1_1_0_000_0_0_0, 12'b1_100_0_100_0_0_1_1);
        add(9'b1_1_0_000_0_0_0, 12'b1_101_0_100_0_0_0_1);
        add(9'b1_1_0_000_0_0_0, 12'b1_110_0_100_0_0_0_1);
        add(9'b1_1_0_000_0_0_0, 12'b1_111_0_100_0_0_0_1);
        add(9'b1_0_1_100_1_1_0, 12'b1_000_0_100_0_0_0_0);
        add(9'b1_0_1_101_1_1_1, 12'b1_000_1_100_0_0_0_0);
        add(9'b1_1_1_110_0_0_1, 12'b0_000_0_100_1_0_0_0);
        add(9'b1_0_1_101_0_0_0, 12'b1_000_0_000_0_0_1_0);
        add(9'b1_0_1_110_0_0_0, 12'b1_000_0_000_0_0_1_0);
        add(9'b1_1_0_000_0_0_0, 12'b1_000_0_000_0_0_1_1);
        add(9'b1_0_0_000_1_0_1, 12'b1_001_0_000_0_0_0_0);
        // correctly predicted BR retires normally
        add(9'b1_0_1_000_1_0_0, 12'b1_001_0_000_0_0_0_0);
        add(9'b1_0_0_000_1_0_1, 12'b1_001_1_000_0_0_0_0);
        add(9'b1_0_0_000_0_0_0, 12'b1_001_0_001_0_0_1_0);
        add(9'b0_0_0_000_0_0_0, 12'b0_001_0_001_0_0_1_0);

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // wrap: 20 alloc / complete / commit triples
        for (int i = 0; i < 20; i++) begin
            logic [2:0] t, t1;
            t  = i[2:0];
            t1 = t + 3'd1;
            v.in  = 9'b1_1_0_000_0_0_0;
            v.exp = {1'b1, t, 1'b0, t, 1'b0, 1'b0, 1'b1, 1'b1};
            apply(v, $sformatf("wrap%0d_alloc", i));
            v.in  = {3'b101, t, 3'b000};
            v.exp = {1'b1, t1, 1'b0, t, 1'b0, 1'b0, 1'b0, 1'b0};
            apply(v, $sformatf("wrap%0d_cdb", i));
            v.in  = 9'b1_0_0_000_0_0_1;
            v.exp = {1'b1, t1, 1'b1, t, 1'b0, 1'b0, 1'b0, 1'b0};
            apply(v, $sformatf("wrap%0d_commit", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
